processor_datapath: RTL and testbench

Datapath end of the 10-bit processor's control interface. Consumes the per-timestep control strobes (Rin/Rout, ENW/ENR, Ain/Gin/Gout, ALUcont, Ext, IRin, Clr) and returns the controller's inputs: the instruction word INSTR and the timestep T. Contains:
- 4x10 register file
- shared bus mux
- A operand register, ALU, G result register
- instruction register
- 2-bit timestep counter

---
 rtl/processor_datapath_if.sv | 44 ++++
 rtl/processor_datapath.sv | 124 ++++++++++++
 tb/tb_processor_datapath.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/processor_datapath_if.sv
// Control/status bundle between the instruction controller and the processor datapath.
// FLAGS exists only when DATAPATH_FLAGS_EN is defined.
interface processor_datapath_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] DIN;
    logic [1:0]       Rin;
    logic [1:0]       Rout;
    logic             ENW;
    logic             ENR;
    logic             Ain;
    logic             Gin;
    logic             Gout;
    logic [3:0]       ALUcont;
    logic             Ext;
    logic             IRin;
    logic             Clr;
    logic [WIDTH-1:0] INSTR;
    logic [1:0]       T;
    logic [WIDTH-1:0] BUS;
    logic [WIDTH-1:0] R0;
    logic [WIDTH-1:0] R1;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;
`ifdef DATAPATH_FLAGS_EN
    logic [2:0]       FLAGS;
`endif

    modport master (
        output DIN, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, Ext, IRin, Clr,
`ifdef DATAPATH_FLAGS_EN
        input  FLAGS,
`endif
        input  INSTR, T, BUS, R0, R1, R2, R3
    );

    modport slave (
        input  DIN, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, Ext, IRin, Clr,
`ifdef DATAPATH_FLAGS_EN
        output FLAGS,
`endif
        output INSTR, T, BUS, R0, R1, R2, R3
    );
endinterface

// File: rtl/processor_datapath.sv
// Datapath of the 10-bit processor: register file, shared bus, A/ALU/G, IR and timestep counter.
// Optional {Z,N,C} flag register is enabled by defining DATAPATH_FLAGS_EN.
module processor_datapath #(
    parameter int WIDTH = 10,
    parameter int NREG  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    processor_datapath_if.slave  dp
);
    localparam int AW = $clog2(NREG);

    logic [WIDTH-1:0] r_q [NREG];
    logic [WIDTH-1:0] r_d [NREG];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [1:0]       t_q, t_d;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       shamt;

    // Fixed bus priority: external data, then G, then the register file.
    always_comb begin
        bus = '0;
        if (dp.Ext)
            bus = dp.DIN;
        else if (dp.Gout)
            bus = g_q;
        else if (dp.ENR)
            bus = r_q[dp.Rout];
    end

    assign shamt = bus[3:0];

    always_comb begin
        alu_res = bus;
        case (dp.ALUcont)
            4'b0010: alu_res = a_q + bus;
            4'b0011: alu_res = a_q - bus;
            4'b0100: alu_res = -bus;
            4'b0101: alu_res = ~bus;
            4'b0110: alu_res = a_q & bus;
            4'b0111: alu_res = a_q | bus;
            4'b1000: alu_res = a_q ^ bus;
            4'b1001: alu_res = a_q << shamt;
            4'b1010: alu_res = a_q >> shamt;
            4'b1011: alu_res = WIDTH'($signed(a_q) >>> shamt);
            default: alu_res = bus;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf_next
            always_comb begin
                r_d[gi] = r_q[gi];
                if (dp.ENW && (dp.Rin == AW'(gi)))
                    r_d[gi] = bus;
            end
        end
    endgenerate

    always_comb begin
        a_d  = dp.Ain  ? bus : a_q;
        g_d  = dp.Gin  ? alu_res : g_q;
        ir_d = dp.IRin ? bus : ir_q;
        t_d  = dp.Clr  ? 2'd0 : t_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_q[i] <= '0;
            a_q  <= '0;
            g_q  <= '0;
            ir_q <= '0;
            t_q  <= 2'd0;
        end else begin
            for (int i = 0; i < NREG; i++)
                r_q[i] <= r_d[i];
            a_q  <= a_d;
            g_q  <= g_d;
            ir_q <= ir_d;
            t_q  <= t_d;
        end
    end

`ifdef DATAPATH_FLAGS_EN
    logic [WIDTH:0] add_ext;
    logic           carry;
    logic [2:0]     flags_q, flags_d;

    assign add_ext = {1'b0, a_q} + {1'b0, bus};

    // C is meaningful only for add (carry out) and sub (no borrow).
    always_comb begin
        carry = 1'b0;
        if (dp.ALUcont == 4'b0010)
            carry = add_ext[WIDTH];
        else if (dp.ALUcont == 4'b0011)
            carry = (a_q >= bus);
        flags_d = flags_q;
        if (dp.Gin)
            flags_d = {(alu_res == '0), alu_res[WIDTH-1], carry};
    end

    always_ff @(posedge clk) begin
        if (reset)
            flags_q <= 3'b000;
        else
            flags_q <= flags_d;
    end

    assign dp.FLAGS = flags_q;
`endif

    assign dp.BUS   = bus;
    assign dp.INSTR = ir_q;
    assign dp.T     = t_q;
    assign dp.R0    = r_q[0];
    assign dp.R1    = r_q[1];
    assign dp.R2    = r_q[2];
    assign dp.R3    = r_q[3];
endmodule

// File: tb/tb_processor_datapath.sv
// Directed bench for processor_datapath: hand-computed vectors checked with immediate assertions.
module tb_processor_datapath;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    processor_datapath_if #(.WIDTH(10)) dpif ();

    processor_datapath #(.WIDTH(10), .NREG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dpif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-12s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        dpif.DIN = '0; dpif.Rin = '0; dpif.Rout = '0; dpif.ENW = 0; dpif.ENR = 0;
        dpif.Ain = 0; dpif.Gin = 0; dpif.Gout = 0; dpif.ALUcont = 4'b0000;
        dpif.Ext = 0; dpif.IRin = 0; dpif.Clr = 0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Drive DIN onto the bus and clock it into A.
    task automatic load_a(input logic [9:0] v);
        dpif.Ext = 1; dpif.DIN = v; dpif.Ain = 1;
        edge_step();
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [9:0] b);
        dpif.Ext = 1; dpif.DIN = b; dpif.Gin = 1; dpif.ALUcont = op;
        edge_step();
    endtask

    task automatic check_g(input string tag, input logic [9:0] exp);
        dpif.Gout = 1;
        #1;
        chk(tag, 16'(dpif.BUS), 16'(exp));
        dpif.Gout = 0;
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        // Reset must override strobes driven in the same cycle.
        dpif.ENW = 1; dpif.Rin = 2'd1; dpif.Ext = 1; dpif.DIN = 10'h3FF; dpif.Clr = 0;
        @(posedge clk);
        #1;
        reset = 0;
        idle();
        chk("rst_R0", 16'(dpif.R0), 16'h0);
        chk("rst_R1", 16'(dpif.R1), 16'h0);
        chk("rst_R2", 16'(dpif.R2), 16'h0);
        chk("rst_R3", 16'(dpif.R3), 16'h0);
        chk("rst_INSTR", 16'(dpif.INSTR), 16'h0);
        chk("rst_T", 16'(dpif.T), 16'h0);
`ifdef DATAPATH_FLAGS_EN
        chk("rst_FLAGS", 16'(dpif.FLAGS), 16'h0);
`endif
        check_g("rst_G", 10'h000);

        // Free-running timestep counter.
        edge_step(); chk("T_run1", 16'(dpif.T), 16'd1);
        edge_step(); chk("T_run2", 16'(dpif.T), 16'd2);
        edge_step(); chk("T_run3", 16'(dpif.T), 16'd3);
        edge_step(); chk("T_run4", 16'(dpif.T), 16'd0);
        edge_step(); chk("T_run5", 16'(dpif.T), 16'd1);
        edge_step(); chk("T_pre_clr", 16'(dpif.T), 16'd2);
        dpif.Clr = 1; edge_step(); chk("T_clr", 16'(dpif.T), 16'd0);
        dpif.Clr = 1; edge_step(); chk("T_clr_hold1", 16'(dpif.T), 16'd0);
        dpif.Clr = 1; edge_step(); chk("T_clr_hold2", 16'(dpif.T), 16'd0);

        // Load and copy through the register file.
        dpif.Ext = 1; dpif.DIN = 10'h155; dpif.ENW = 1; dpif.Rin = 2'd2;
        edge_step();
        chk("load_R2", 16'(dpif.R2), 16'h155);
        chk("load_R0", 16'(dpif.R0), 16'h000);
        dpif.ENR = 1; dpif.Rout = 2'd2; dpif.ENW = 1; dpif.Rin = 2'd0;
        #1;
        chk("copy_bus", 16'(dpif.BUS), 16'h155);
        edge_step();
        chk("copy_R0", 16'(dpif.R0), 16'h155);
        chk("copy_R2", 16'(dpif.R2), 16'h155);
        chk("copy_R1", 16'(dpif.R1), 16'h000);
        dpif.ENR = 1; dpif.Rout = 2'd2; dpif.ENW = 1; dpif.Rin = 2'd2;
        edge_step();
        chk("selfcopy_R2", 16'(dpif.R2), 16'h155);

        // Add with wrap-around.
        load_a(10'h3FF);
        alu_op(4'b0010, 10'h002);
        check_g("add_wrap", 10'h001);
`ifdef DATAPATH_FLAGS_EN
        chk("add_flags", 16'(dpif.FLAGS), 16'b001);
`endif
        load_a(10'h005);
        alu_op(4'b0011, 10'h007);
        check_g("sub_neg", 10'h3FE);
`ifdef DATAPATH_FLAGS_EN
        chk("sub_flags", 16'(dpif.FLAGS), 16'b010);
`endif
        load_a(10'h200);
        alu_op(4'b1011, 10'h003);
        check_g("asr3", 10'h3C0);
        alu_op(4'b1011, 10'h00C);
        check_g("asr12", 10'h3FF);
        alu_op(4'b1010, 10'h003);
        check_g("lsr3", 10'h040);
        alu_op(4'b1001, 10'h001);
        check_g("lsl1", 10'h000);
        alu_op(4'b0100, 10'h001);
        check_g("neg", 10'h3FF);
        alu_op(4'b0101, 10'h0F0);
        check_g("not", 10'h30F);
        alu_op(4'b0110, 10'h3C0);
        check_g("and", 10'h200);
        alu_op(4'b0111, 10'h00F);
        check_g("or", 10'h20F);
        alu_op(4'b1000, 10'h300);
        check_g("xor", 10'h100);
        alu_op(4'b0000, 10'h123);
        check_g("pass", 10'h123);

        // Ain and Gin together: the ALU sees the old A (0x200).
        dpif.Ext = 1; dpif.DIN = 10'h001; dpif.Ain = 1; dpif.Gin = 1; dpif.ALUcont = 4'b0010;
        edge_step();
        check_g("ain_gin", 10'h201);
        alu_op(4'b1001, 10'h003);
        check_g("lsl_newA", 10'h008);
`ifdef DATAPATH_FLAGS_EN
        chk("lsl_flags", 16'(dpif.FLAGS), 16'b000);
`endif
        // Gout and Gin together: old G (0x008) on the bus, A=1.
        dpif.Gout = 1; dpif.Gin = 1; dpif.ALUcont = 4'b0010;
        edge_step();
        check_g("gout_gin", 10'h009);

        // Bus priority.
        alu_op(4'b0000, 10'h111);
        dpif.Ext = 1; dpif.DIN = 10'h0AA; dpif.Gout = 1; dpif.ENR = 1; dpif.Rout = 2'd2; dpif.IRin = 1;
        #1;
        chk("prio_ext", 16'(dpif.BUS), 16'h0AA);
        edge_step();
        chk("ir_load", 16'(dpif.INSTR), 16'h0AA);
        dpif.Gout = 1; dpif.ENR = 1; dpif.Rout = 2'd2;
        #1;
        chk("prio_gout", 16'(dpif.BUS), 16'h111);
        dpif.Gout = 0;
        #1;
        chk("prio_enr", 16'(dpif.BUS), 16'h155);
        dpif.ENR = 0;
        #1;
        chk("bus_idle", 16'(dpif.BUS), 16'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
